// File: rtl/exec_mdu_ctrl.sv
// exec_mdu_ctrl: EX-stage ALU control decode plus an iterative radix-2 multiply/divide unit.
module exec_mdu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [4:0]      ALUControl,
  output logic            stall,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
  localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010, OP_XOR = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100, OP_SRL = 5'b00101, OP_SUB = 5'b00110, OP_SRA = 5'b00111;
  localparam logic [4:0] OP_SLT = 5'b01000, OP_SLTU = 5'b01001, OP_INV = 5'b11111;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, step, prod;
  logic [XLEN-1:0]   opb, a_mag, b_mag, fast_res, quo, rem, final_res;
  logic [XLEN:0]     msum, dsub;
  logic [1:0]        op;
  logic [4:0]        base_ctl;
  logic              neg_q, neg_r, is_mop, accept, div_op, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, fast;
  always_comb
    case (funct3)
      3'b000:  base_ctl = OP_ADD;
      3'b001:  base_ctl = OP_SLL;
      3'b010:  base_ctl = OP_SLT;
      3'b011:  base_ctl = OP_SLTU;
      3'b100:  base_ctl = OP_XOR;
      3'b101:  base_ctl = OP_SRL;
      3'b110:  base_ctl = OP_OR;
      default: base_ctl = OP_AND;
    endcase
  assign is_mop = ALUOp == 2'b10 && funct7 == 7'b0000001;
  assign ALUControl = ALUOp == 2'b00 ? OP_ADD
                    : ALUOp == 2'b01 ? OP_SUB
                    : ALUOp == 2'b11 ? ((funct3 == 3'b101 && funct7[5]) ? OP_SRA : base_ctl)
                    : funct7 == 7'b0000000 ? base_ctl
                    : funct7 == 7'b0100000 ? (funct3 == 3'b000 ? OP_SUB : funct3 == 3'b101 ? OP_SRA : OP_INV)
                    : OP_INV;
  assign accept   = state == IDLE && valid_in && !flush && !reset && is_mop;
  assign stall    = !reset && !flush && (accept || state == MUL || state == DIV);
  assign mdu_done = state == DONE;
  // a is signed for MUL/MULH/MULHSU/DIV/REM, b only for MUL/MULH/DIV/REM
  assign div_op   = funct3[2];
  assign a_sgn    = funct3 != 3'b011 && !(funct3[2] && funct3[0]);
  assign b_sgn    = a_sgn && funct3 != 3'b010;
  assign a_neg    = a_sgn && a[XLEN-1];
  assign b_neg    = b_sgn && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div0     = div_op && b == '0;
  assign ovf      = div_op && !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
  assign fast     = div0 || ovf;
  assign fast_res = div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
  // acc holds {hi, lo} of the product for multiply and {remainder, quotient} for divide
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb & {XLEN{acc[0]}}};
  assign dsub = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
  assign step = state == MUL ? {msum, acc[XLEN-1:1]}
              : dsub[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
              : {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign prod = neg_q ? -step : step;
  assign quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem  = neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
  assign final_res = state == MUL ? (op == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                   : (op[1] ? rem : quo);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mdu_result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state <= fast ? DONE : div_op ? DIV : MUL;
      cnt   <= CW'(XLEN - 1);
      acc   <= {{XLEN{1'b0}}, div_op ? a_mag : b_mag};
      opb   <= div_op ? b_mag : a_mag;
      op    <= funct3[1:0];
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (fast) mdu_result <= fast_res;
    end else if (state == MUL || state == DIV) begin
      acc <= step;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        state      <= DONE;
        mdu_result <= final_res;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_exec_mdu_ctrl.sv
// tb_exec_mdu_ctrl: directed literal checks plus randomized traffic against a behavioural model.
module tb_exec_mdu_ctrl;
  localparam logic [63:0] MINV = 64'h8000000000000000;
  localparam logic [39:0] TBL  = {5'd0, 5'd1, 5'd5, 5'd3, 5'd9, 5'd8, 5'd4, 5'd2};
  logic clk = 0, reset = 1, valid_in = 0, flush = 0;
  logic [1:0] ALUOp = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [63:0] a = 0, b = 0;
  logic [4:0] ALUControl;
  logic stall, mdu_done;
  logic [63:0] mdu_result;
  int n_chk = 0, n_fail = 0;
  int m_busy = 0;
  logic m_done = 0, m_init = 0;
  logic [63:0] m_res = 0, m_pend = 0;

  exec_mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush), .ALUOp(ALUOp),
    .funct3(funct3), .funct7(funct7), .a(a), .b(b), .ALUControl(ALUControl),
    .stall(stall), .mdu_done(mdu_done), .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [4:0] base;
    base = TBL[int'(f3)*5 +: 5];
    if (op == 2'b00) return 5'd2;
    if (op == 2'b01) return 5'd6;
    if (op == 2'b11) return (f3 == 3'd5 && f7[5]) ? 5'd7 : base;
    if (f7 == 7'h00) return base;
    if (f7 == 7'h20) return f3 == 3'd0 ? 5'd6 : f3 == 3'd5 ? 5'd7 : 5'd31;
    return 5'd31;
  endfunction

  function automatic logic [63:0] mdu_ref(input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xs, ys, p;
    logic signed [63:0] sx, sy, sr;
    logic ov;
    xs = {{64{x[63]}}, x};
    ys = {{64{y[63]}}, y};
    sx = x;
    sy = y;
    ov = x == MINV && y == '1;
    case (f3)
      3'd0: begin p = xs * ys; return p[63:0]; end
      3'd1: begin p = xs * ys; return p[127:64]; end
      3'd2: begin p = xs * {64'b0, y}; return p[127:64]; end
      3'd3: begin p = {64'b0, x} * {64'b0, y}; return p[127:64]; end
      3'd4: begin
        if (y == 0) return '1;
        if (ov) return x;
        sr = sx / sy;
        return sr;
      end
      3'd5: return y == 0 ? '1 : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ov) return '0;
        sr = sx % sy;
        return sr;
      end
      default: return y == 0 ? x : x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y);
    return f3[2] && (y == 0 || (!f3[0] && x == MINV && y == '1));
  endfunction

  // Behavioural model: an accepted op produces its result 64 busy cycles later (or at once on the fast path)
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_res <= '0; m_init <= 1;
    end else if (flush) begin
      m_busy <= 0; m_done <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin m_done <= 1; m_res <= m_pend; end
    end else if (m_done) begin
      m_done <= 0;
    end else if (valid_in && ALUOp == 2'b10 && funct7 == 7'h01) begin
      if (is_fast(funct3, a, b)) begin m_done <= 1; m_res <= mdu_ref(funct3, a, b); end
      else begin m_busy <= 64; m_pend <= mdu_ref(funct3, a, b); end
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("alu_ctl", 64'(ALUControl), 64'(exp_alu(ALUOp, funct3, funct7)));
    chk("stall", 64'(stall), 64'(!reset && !flush &&
        (m_busy > 0 || (!m_done && valid_in && ALUOp == 2'b10 && funct7 == 7'h01))));
    chk("mdu_done", 64'(mdu_done), 64'(m_done));
    chk("mdu_result", mdu_result, m_res);
  end

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] x, input logic [63:0] y, input logic v);
    @(posedge clk); #1;
    ALUOp = op; funct3 = f3; funct7 = f7; a = x; b = y; valid_in = v; flush = 0; reset = 0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y,
                        input int lat, input logic [63:0] exp);
    drive(2'b10, f3, 7'h01, x, y, 1);
    @(negedge clk);
    chk({nm, "_stall_acc"}, 64'(stall), 64'd1);
    repeat (lat - 1) @(negedge clk);
    chk({nm, "_stall_last"}, 64'(stall), 64'd1);
    chk({nm, "_early_done"}, 64'(mdu_done), 64'd0);
    @(negedge clk);
    chk({nm, "_done"}, 64'(mdu_done), 64'd1);
    chk({nm, "_result"}, mdu_result, exp);
    chk({nm, "_stall_done"}, 64'(stall), 64'd0);
    drive(2'b00, 3'd0, 7'd0, 64'd0, 64'd0, 0);
    @(negedge clk);
    chk({nm, "_no_restart"}, 64'(stall), 64'd0);
    chk({nm, "_done_off"}, 64'(mdu_done), 64'd0);
    chk({nm, "_held"}, mdu_result, exp);
  endtask

  task automatic abort_op(input bit use_rst, input logic [63:0] exp_res);
    string nm;
    int seen;
    nm = use_rst ? "rst_abort" : "flush_abort";
    seen = 0;
    drive(2'b10, 3'b100, 7'h01, 64'd1000, 64'd7, 1);
    drive(2'b00, 3'd0, 7'd0, 64'd0, 64'd0, 0);
    chk({nm, "_busy"}, 64'(stall), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) reset = 1; else flush = 1;
    @(negedge clk);
    chk({nm, "_stall_kill"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 0; flush = 0;
    @(negedge clk);
    chk({nm, "_stall_after"}, 64'(stall), 64'd0);
    chk({nm, "_result"}, mdu_result, exp_res);
    repeat (70) begin
      @(negedge clk);
      if (mdu_done) seen++;
    end
    chk({nm, "_no_done"}, 64'(seen), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(mdu_done), 64'd0);
    chk("rst_result", mdu_result, 64'd0);
    drive(2'b10, 3'b000, 7'h20, 64'd5, 64'd3, 1);
    @(negedge clk);
    chk("sub_ctl", 64'(ALUControl), 64'b00110);
    chk("sub_stall", 64'(stall), 64'd0);
    run_op("mul", 3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 65, 64'hFFFFFFFFFFFFFFEB);
    run_op("divu0", 3'b101, 64'd100, 64'd0, 1, 64'hFFFFFFFFFFFFFFFF);
    run_op("rem0", 3'b110, 64'd100, 64'd0, 1, 64'd100);
    run_op("div_ovf", 3'b100, MINV, 64'hFFFFFFFFFFFFFFFF, 1, MINV);
    run_op("mulhu", 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 65, 64'hFFFFFFFFFFFFFFFE);
    run_op("div_neg", 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 65, 64'hFFFFFFFFFFFFFFFD);
    run_op("rem_neg", 3'b110, 64'hFFFFFFFFFFFFFFF9, 64'd2, 65, 64'hFFFFFFFFFFFFFFFF);
    abort_op(0, 64'hFFFFFFFFFFFFFFFF);
    abort_op(1, 64'd0);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      reset    = $urandom_range(0, 599) == 0;
      flush    = $urandom_range(0, 149) == 0;
      valid_in = $urandom_range(0, 3) != 0;
      funct3   = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ALUOp = 2'b10; funct7 = 7'h01;
      end else begin
        ALUOp = 2'($urandom);
        case ($urandom_range(0, 3))
          0: funct7 = 7'h00;
          1: funct7 = 7'h20;
          2: funct7 = 7'h01;
          default: funct7 = 7'($urandom);
        endcase
      end
      a = pick();
      b = pick();
    end
    @(posedge clk); #1;
    valid_in = 0; flush = 0; reset = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
